// File: rtl/priv_access_ctrl.sv
// Privilege-checked access gate between a CPU register port and a register bank.
// Programmable address windows with per-window minimum privilege; denied accesses are logged.
module priv_access_ctrl #(
  parameter int          ADDR_W       = 12,
  parameter int          DATA_W       = 32,
  parameter int          NUM_REGIONS  = 4,
  parameter logic [1:0]  MACHINE_PRIV = 2'b11,
  parameter int          FCNT_W       = 8,
  localparam int         IDX_W        = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_priv,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic              dn_write,
  output logic [ADDR_W-1:0] dn_addr,
  output logic [DATA_W-1:0] dn_wdata,
  input  logic              dn_rsp_valid,
  input  logic [DATA_W-1:0] dn_rdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_err,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              except,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_priv,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W-1:0] cfg_limit,
  input  logic [1:0]        cfg_min_priv,
  input  logic              cfg_en,
  input  logic              cfg_lock,
  output logic [ADDR_W-1:0] fault_addr,
  output logic [1:0]        fault_priv,
  output logic              fault_write,
  output logic [FCNT_W-1:0] fault_count
);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_FWD, S_WAIT, S_RESP} state_t;

  state_t              r_state, w_next;
  logic                r_write;
  logic [1:0]          r_priv;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_err;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_except;
  logic [ADDR_W-1:0]   r_faddr;
  logic [1:0]          r_fpriv;
  logic                r_fwrite;
  logic [FCNT_W-1:0]   r_fcnt;

  logic [ADDR_W-1:0]   r_base  [NUM_REGIONS];
  logic [ADDR_W-1:0]   r_limit [NUM_REGIONS];
  logic [1:0]          r_min   [NUM_REGIONS];
  logic                r_en    [NUM_REGIONS];
  logic                r_lock  [NUM_REGIONS];

  logic                w_hit;
  logic [1:0]          w_min;
  logic                w_allowed;

  // First matching window in index order decides; no match needs full machine privilege.
  always_comb begin
    w_hit = 1'b0;
    w_min = MACHINE_PRIV;
    for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
      if (!w_hit && r_en[i] && (r_base[i] <= r_addr) && (r_addr <= r_limit[i])) begin
        w_hit = 1'b1;
        w_min = r_min[i];
      end
    end
    w_allowed = w_hit ? (r_priv >= w_min) : (r_priv == MACHINE_PRIV);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (req_valid) w_next = S_CHECK;
      S_CHECK: w_next = w_allowed ? S_FWD : S_RESP;
      S_FWD:   if (dn_ready) w_next = dn_rsp_valid ? S_RESP : S_WAIT;
      S_WAIT:  if (dn_rsp_valid) w_next = S_RESP;
      S_RESP:  if (resp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_write  <= 1'b0;
      r_priv   <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
      r_except <= 1'b0;
      r_faddr  <= '0;
      r_fpriv  <= '0;
      r_fwrite <= 1'b0;
      r_fcnt   <= '0;
    end else begin
      r_except <= 1'b0;
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_write <= req_write;
          r_priv  <= req_priv;
          r_addr  <= req_addr;
          r_wdata <= req_wdata;
        end
        S_CHECK: if (!w_allowed) begin
          r_err    <= 1'b1;
          r_rdata  <= '0;
          r_except <= 1'b1;
          r_faddr  <= r_addr;
          r_fpriv  <= r_priv;
          r_fwrite <= r_write;
          if (r_fcnt != '1) r_fcnt <= r_fcnt + FCNT_W'(1);
        end
        S_FWD: if (dn_ready && dn_rsp_valid) begin
          r_err   <= 1'b0;
          r_rdata <= r_write ? '0 : dn_rdata;
        end
        S_WAIT: if (dn_rsp_valid) begin
          r_err   <= 1'b0;
          r_rdata <= r_write ? '0 : dn_rdata;
        end
        default: ;
      endcase
    end
  end

  // Region table; a locked entry ignores every later write until reset.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
      if (!rst_n) begin
        r_base[i]  <= '0;
        r_limit[i] <= '0;
        r_min[i]   <= MACHINE_PRIV;
        r_en[i]    <= 1'b0;
        r_lock[i]  <= 1'b0;
      end else if (cfg_we && (cfg_priv == MACHINE_PRIV) && !r_lock[i] && (32'(cfg_idx) == i)) begin
        r_base[i]  <= cfg_base;
        r_limit[i] <= cfg_limit;
        r_min[i]   <= cfg_min_priv;
        r_en[i]    <= cfg_en;
        r_lock[i]  <= cfg_lock;
      end
    end
  end

  assign req_ready   = (r_state == S_IDLE);
  assign dn_valid    = (r_state == S_FWD);
  assign resp_valid  = (r_state == S_RESP);
  assign dn_write    = r_write;
  assign dn_addr     = r_addr;
  assign dn_wdata    = r_wdata;
  assign resp_err    = r_err;
  assign resp_rdata  = r_rdata;
  assign except      = r_except;
  assign fault_addr  = r_faddr;
  assign fault_priv  = r_fpriv;
  assign fault_write = r_fwrite;
  assign fault_count = r_fcnt;

endmodule

// File: tb/tb_priv_access_ctrl.sv
// Self-checking bench for priv_access_ctrl: directed scenarios plus randomized traffic
// against a table-based access model; a second instance uses a 2-bit fault counter.
module tb_priv_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [1:0]  req_priv = '0;
  logic [11:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        dn_ready = 1'b0, dn_rsp_valid = 1'b0;
  logic [31:0] dn_rdata = '0;
  logic        resp_ready = 1'b0;
  logic        cfg_we = 1'b0, cfg_en = 1'b0, cfg_lock = 1'b0;
  logic [1:0]  cfg_priv = '0, cfg_idx = '0, cfg_min_priv = '0;
  logic [11:0] cfg_base = '0, cfg_limit = '0;

  logic        req_ready, dn_valid, dn_write, resp_valid, resp_err, except, fault_write;
  logic [11:0] dn_addr, fault_addr;
  logic [31:0] dn_wdata, resp_rdata;
  logic [1:0]  fault_priv;
  logic [7:0]  fault_count;

  logic        s_req_ready, s_dn_valid, s_dn_write, s_resp_valid, s_resp_err, s_except, s_fault_write;
  logic [11:0] s_dn_addr, s_fault_addr;
  logic [31:0] s_dn_wdata, s_resp_rdata;
  logic [1:0]  s_fault_priv;
  logic [1:0]  s_fault_count;

  int errors = 0, checks = 0;
  int exc_seen = 0, s_exc_seen = 0;

  always #5 clk = ~clk;

  priv_access_ctrl #(.ADDR_W(12), .DATA_W(32), .NUM_REGIONS(4), .MACHINE_PRIV(2'b11), .FCNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_priv(req_priv), .req_addr(req_addr), .req_wdata(req_wdata), .dn_valid(dn_valid),
    .dn_ready(dn_ready), .dn_write(dn_write), .dn_addr(dn_addr), .dn_wdata(dn_wdata),
    .dn_rsp_valid(dn_rsp_valid), .dn_rdata(dn_rdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_err(resp_err), .resp_rdata(resp_rdata), .except(except), .cfg_we(cfg_we), .cfg_priv(cfg_priv),
    .cfg_idx(cfg_idx), .cfg_base(cfg_base), .cfg_limit(cfg_limit), .cfg_min_priv(cfg_min_priv),
    .cfg_en(cfg_en), .cfg_lock(cfg_lock), .fault_addr(fault_addr), .fault_priv(fault_priv),
    .fault_write(fault_write), .fault_count(fault_count));

  priv_access_ctrl #(.ADDR_W(12), .DATA_W(32), .NUM_REGIONS(4), .MACHINE_PRIV(2'b11), .FCNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(s_req_ready), .req_write(req_write),
    .req_priv(req_priv), .req_addr(req_addr), .req_wdata(req_wdata), .dn_valid(s_dn_valid),
    .dn_ready(dn_ready), .dn_write(s_dn_write), .dn_addr(s_dn_addr), .dn_wdata(s_dn_wdata),
    .dn_rsp_valid(dn_rsp_valid), .dn_rdata(dn_rdata), .resp_valid(s_resp_valid), .resp_ready(resp_ready),
    .resp_err(s_resp_err), .resp_rdata(s_resp_rdata), .except(s_except), .cfg_we(cfg_we), .cfg_priv(cfg_priv),
    .cfg_idx(cfg_idx), .cfg_base(cfg_base), .cfg_limit(cfg_limit), .cfg_min_priv(cfg_min_priv),
    .cfg_en(cfg_en), .cfg_lock(cfg_lock), .fault_addr(s_fault_addr), .fault_priv(s_fault_priv),
    .fault_write(s_fault_write), .fault_count(s_fault_count));

  always @(negedge clk) begin
    if (except)   exc_seen++;
    if (s_except) s_exc_seen++;
  end

  // Reference model: region table and fault log
  logic [11:0] m_base [4], m_limit [4];
  logic [1:0]  m_min [4];
  bit          m_en [4], m_lock [4];
  logic [11:0] m_faddr;
  logic [1:0]  m_fpriv;
  logic        m_fwrite;
  int          m_cnt, m_total;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 4; i++) begin
      m_base[i] = '0; m_limit[i] = '0; m_min[i] = 2'b11; m_en[i] = 0; m_lock[i] = 0;
    end
    m_faddr = '0; m_fpriv = '0; m_fwrite = 0; m_cnt = 0;
  endtask

  function automatic bit m_allowed(input logic [1:0] p, input logic [11:0] a);
    for (int i = 0; i < 4; i++)
      if (m_en[i] && a >= m_base[i] && a <= m_limit[i]) return (p >= m_min[i]);
    return (p == 2'b11);
  endfunction

  task automatic cfg_set(input int idx, input logic [11:0] b, input logic [11:0] l,
                         input logic [1:0] mp, input bit en, input bit lk, input logic [1:0] cp);
    cfg_we = 1; cfg_idx = 2'(idx); cfg_base = b; cfg_limit = l;
    cfg_min_priv = mp; cfg_en = en; cfg_lock = lk; cfg_priv = cp;
    if (cp == 2'b11 && !m_lock[idx] && idx < 4) begin
      m_base[idx] = b; m_limit[idx] = l; m_min[idx] = mp; m_en[idx] = en; m_lock[idx] = lk;
    end
  endtask

  task automatic cfg_write(input int idx, input logic [11:0] b, input logic [11:0] l,
                           input logic [1:0] mp, input bit en, input bit lk, input logic [1:0] cp);
    cfg_set(idx, b, l, mp, en, lk, cp);
    @(negedge clk);
    cfg_we = 0;
  endtask

  task automatic chk_faults();
    chk("fault_addr", fault_addr, m_faddr);
    chk("fault_priv", fault_priv, m_fpriv);
    chk("fault_write", fault_write, m_fwrite);
    chk("fault_count", fault_count, (m_cnt > 255) ? 255 : m_cnt);
    chk("sat_fault_count", s_fault_count, (m_cnt > 3) ? 3 : m_cnt);
  endtask

  // One full transaction starting from an IDLE negedge. cfg_now fires a machine write
  // to region 3 (fields in arguments) during the CHECK cycle.
  task automatic do_req(input logic w, input logic [1:0] p, input logic [11:0] a,
                        input logic [31:0] wd, input logic [31:0] rd, input int dn_dly,
                        input int rsp_dly, input bit sep, input bit cfg_now,
                        input logic [1:0] cn_min);
    bit ok;
    logic [31:0] erd;
    ok  = m_allowed(p, a);
    erd = (ok && !w) ? rd : 32'h0;
    chk("idle_ready", req_ready, 1);
    req_valid = 1; req_write = w; req_priv = p; req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 0; req_addr = 12'($urandom); req_wdata = $urandom; req_write = ~w;
    chk("check_ready", req_ready, 0);
    chk("check_dn_valid", dn_valid, 0);
    chk("check_resp_valid", resp_valid, 0);
    if (cfg_now) cfg_set(3, m_base[3], m_limit[3], cn_min, 1, 0, 2'b11);
    @(negedge clk);
    cfg_we = 0;
    if (!ok) begin
      m_faddr = a; m_fpriv = p; m_fwrite = w; m_cnt++; m_total++;
      chk("deny_except", except, 1);
      chk("deny_resp_valid", resp_valid, 1);
      chk("deny_err", resp_err, 1);
      chk("deny_rdata", resp_rdata, 0);
      chk("deny_dn_valid", dn_valid, 0);
      chk_faults();
    end else begin
      chk("fwd_dn_valid", dn_valid, 1);
      chk("fwd_dn_write", dn_write, w);
      chk("fwd_dn_addr", dn_addr, a);
      chk("fwd_dn_wdata", dn_wdata, wd);
      chk("fwd_resp_valid", resp_valid, 0);
      chk("fwd_except", except, 0);
      for (int k = 0; k < dn_dly; k++) begin
        @(negedge clk);
        chk("bp_dn_valid", dn_valid, 1);
        chk("bp_dn_addr", dn_addr, a);
        chk("bp_dn_wdata", dn_wdata, wd);
        chk("bp_req_ready", req_ready, 0);
      end
      dn_ready = 1; dn_rsp_valid = !sep; dn_rdata = sep ? ~rd : rd;
      @(negedge clk);
      dn_ready = 0; dn_rsp_valid = 0; dn_rdata = $urandom;
      if (sep) begin
        chk("wait_resp_valid", resp_valid, 0);
        chk("wait_dn_valid", dn_valid, 0);
        dn_rsp_valid = 1; dn_rdata = rd;
        @(negedge clk);
        dn_rsp_valid = 0; dn_rdata = $urandom;
      end
      chk("ok_resp_valid", resp_valid, 1);
      chk("ok_err", resp_err, 0);
      chk("ok_rdata", resp_rdata, erd);
    end
    resp_ready = 0;
    for (int k = 0; k < rsp_dly; k++) begin
      @(negedge clk);
      chk("hold_resp_valid", resp_valid, 1);
      chk("hold_rdata", resp_rdata, erd);
      chk("hold_err", resp_err, !ok);
      chk("hold_except", except, 0);
    end
    resp_ready = 1;
    @(negedge clk);
    resp_ready = 0;
    chk("done_resp_valid", resp_valid, 0);
    chk("done_except", except, 0);
    chk("done_ready", req_ready, 1);
    chk_faults();
  endtask

  initial begin
    m_reset();
    m_total = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_dn_valid", dn_valid, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_except", except, 0);
    chk("rst_dn_addr", dn_addr, 0);
    chk_faults();

    // No regions: non-machine denied, machine allowed
    do_req(0, 2'b01, 12'h064, 32'h0, 32'h0, 0, 0, 0, 0, 2'b00);
    do_req(0, 2'b11, 12'h064, 32'h0, 32'hDEADBEEF, 0, 0, 0, 0, 2'b00);

    // Overlapping windows: lowest index wins
    cfg_write(0, 12'h060, 12'h06F, 2'b01, 1, 0, 2'b11);
    cfg_write(1, 12'h064, 12'h064, 2'b11, 1, 0, 2'b11);
    do_req(1, 2'b01, 12'h064, 32'h12345678, 32'h0, 0, 0, 0, 0, 2'b00);
    do_req(1, 2'b00, 12'h064, 32'h0BADF00D, 32'h0, 0, 0, 0, 0, 2'b00);

    // Config from non-machine is dropped
    cfg_write(0, 12'h000, 12'h000, 2'b11, 0, 0, 2'b01);
    do_req(1, 2'b01, 12'h068, 32'hA5A5A5A5, 32'h0, 0, 0, 0, 0, 2'b00);

    // Locked region ignores machine rewrite
    cfg_write(2, 12'h200, 12'h2FF, 2'b00, 1, 1, 2'b11);
    cfg_write(2, 12'h300, 12'h3FF, 2'b11, 1, 0, 2'b11);
    do_req(0, 2'b00, 12'h250, 32'h0, 32'hCAFEF00D, 0, 0, 0, 0, 2'b00);
    do_req(0, 2'b00, 12'h350, 32'h0, 32'h11111111, 0, 0, 0, 0, 2'b00);

    // Backpressure on both sides, plus a separate bank response
    do_req(0, 2'b11, 12'h123, 32'h0, 32'h87654321, 5, 4, 0, 0, 2'b00);
    do_req(0, 2'b01, 12'h066, 32'h0, 32'h55AA55AA, 2, 3, 1, 0, 2'b00);
    do_req(1, 2'b00, 12'h7FF, 32'h1, 32'h0, 0, 4, 0, 0, 2'b00);

    // Config write during CHECK does not affect that decision
    cfg_write(3, 12'h400, 12'h4FF, 2'b11, 1, 0, 2'b11);
    do_req(0, 2'b01, 12'h410, 32'h0, 32'h2222, 0, 0, 0, 1, 2'b00);
    do_req(0, 2'b01, 12'h410, 32'h0, 32'h3333, 0, 0, 0, 0, 2'b00);

    // Saturation of the 2-bit counter instance
    for (int k = 0; k < 5; k++)
      do_req(k[0], 2'b00, 12'h700 + 12'(k), 32'h0, 32'h0, 0, 0, 0, 0, 2'b00);

    // Randomized traffic and config
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        logic [11:0] b;
        b = 12'($urandom_range(0, 12'h5FF));
        cfg_write($urandom_range(0, 3), b, b + 12'($urandom_range(0, 12'h1FF)),
                  2'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                  ($urandom_range(0, 3) == 0) ? 2'b01 : 2'b11);
      end
      do_req(1'($urandom), 2'($urandom), 12'($urandom_range(0, 12'h6FF)), $urandom, $urandom,
             $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom), 0, 2'b00);
    end

    @(negedge clk);
    chk("except_pulses", exc_seen, m_total);
    chk("sat_except_pulses", s_exc_seen, m_total);

    // Reset while waiting for the bank response
    req_valid = 1; req_write = 0; req_priv = 2'b11; req_addr = 12'h123;
    @(negedge clk);
    req_valid = 0;
    @(negedge clk);
    chk("pre_rst_dn_valid", dn_valid, 1);
    dn_ready = 1;
    @(negedge clk);
    dn_ready = 0;
    chk("pre_rst_wait", resp_valid, 0);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    m_reset();
    chk("post_rst_ready", req_ready, 1);
    chk("post_rst_resp_valid", resp_valid, 0);
    chk("post_rst_dn_valid", dn_valid, 0);
    chk_faults();
    dn_rsp_valid = 1; dn_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    dn_rsp_valid = 0;
    for (int k = 0; k < 3; k++) begin
      chk("late_rsp_resp_valid", resp_valid, 0);
      chk("late_rsp_ready", req_ready, 1);
      @(negedge clk);
    end
    // Regions were cleared: a supervisor access is now denied again
    do_req(0, 2'b10, 12'h250, 32'h0, 32'h0, 0, 0, 0, 0, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
